// File: rtl/spi_bus_pkg.sv
// Shared definitions for the SPI-to-bus sequencer: state encoding, rw flag
// values and the command-byte address extraction.
package spi_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_SETUP     = 3'd2,
        ST_STROBE    = 3'd3,
        ST_HOLD      = 3'd4
    } state_t;

    localparam logic       RW_READ   = 1'b1;
    localparam logic       RW_WRITE  = 1'b0;
    localparam int         RW_BIT    = 7;
    localparam logic [7:0] ADDR_MASK = 8'h3F;

    // The rw flag occupies the byte MSB, so it is masked out of the shifted address.
    function automatic logic [7:0] addr_shift(input logic [7:0] b);
        return (b >> 1) & ADDR_MASK;
    endfunction

endpackage

// File: rtl/bus_cycle_timer.sv
// Down-counter that times the strobe phase: load a count, o_done marks the
// final cycle of the loaded interval.
module bus_cycle_timer #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_l,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_l) begin
        if (!i_rst_l) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == WIDTH'(1));

endmodule

// File: rtl/spi_bus_sequencer.sv
// Turns SPI command/data bytes into timed peripheral bus cycles, returns read
// data to the SPI transmit byte and flags overrun or lost write data.
module spi_bus_sequencer
    import spi_bus_pkg::*;
#(
    parameter int WAIT_STATES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic       i_clk,
    input  logic       i_rst_l,
    input  logic [7:0] i_rx_byte,
    input  logic       i_rx_valid,
    output logic [7:0] o_tx_byte,
    output logic [7:0] o_bus_addr,
    output logic [7:0] o_bus_wdata,
    input  logic [7:0] i_bus_rdata,
    output logic       o_bus_rw,
    output logic       o_bus_strobe,
    output logic       o_busy,
    output logic       o_err
);

    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    logic [7:0] r_tx;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic       r_rw;
    logic       r_strobe;
    logic       r_busy;
    logic       r_err;
    logic [7:0] r_to_cnt;

    state_t     w_state_next;
    logic [7:0] w_tx_next;
    logic [7:0] w_addr_next;
    logic [7:0] w_wdata_next;
    logic       w_rw_next;
    logic       w_err_next;
    logic [7:0] w_to_next;
    logic       w_timer_load;
    logic       w_timer_done;

    bus_cycle_timer #(.WIDTH(4)) u_timer (
        .i_clk   (i_clk),
        .i_rst_l (i_rst_l),
        .i_load  (w_timer_load),
        .i_value (WS_LOAD),
        .o_done  (w_timer_done)
    );

    always_comb begin
        w_state_next = r_state;
        w_tx_next    = r_tx;
        w_addr_next  = r_addr;
        w_wdata_next = r_wdata;
        w_rw_next    = r_rw;
        w_err_next   = r_err;
        w_to_next    = r_to_cnt;
        w_timer_load = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    w_addr_next = addr_shift(i_rx_byte);
                    if (i_rx_byte[RW_BIT] == RW_READ) begin
                        w_rw_next    = RW_READ;
                        w_state_next = ST_SETUP;
                    end else begin
                        w_to_next    = '0;
                        w_state_next = ST_WAIT_DATA;
                    end
                end
            end
            ST_WAIT_DATA: begin
                // A byte arriving on the expiry cycle still counts as write data.
                if (i_rx_valid) begin
                    w_wdata_next = i_rx_byte;
                    w_rw_next    = RW_WRITE;
                    w_state_next = ST_SETUP;
                end else if (r_to_cnt >= TO_LAST) begin
                    w_err_next   = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (r_to_cnt != 8'hFF) begin
                    w_to_next = r_to_cnt + 8'd1;
                end
            end
            ST_SETUP: begin
                w_timer_load = 1'b1;
                w_state_next = ST_STROBE;
            end
            ST_STROBE: begin
                if (w_timer_done) begin
                    w_state_next = ST_HOLD;
                    if (r_rw == RW_READ) begin
                        w_tx_next = i_bus_rdata;
                    end
                end
            end
            ST_HOLD: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Bytes arriving while a bus cycle is in flight are dropped.
        if (i_rx_valid && (r_state == ST_SETUP || r_state == ST_STROBE || r_state == ST_HOLD)) begin
            w_err_next = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_l) begin
        if (!i_rst_l) begin
            r_state  <= ST_IDLE;
            r_tx     <= 8'h00;
            r_addr   <= 8'h00;
            r_wdata  <= 8'h00;
            r_rw     <= RW_READ;
            r_strobe <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
            r_to_cnt <= 8'h00;
        end else begin
            r_state  <= w_state_next;
            r_tx     <= w_tx_next;
            r_addr   <= w_addr_next;
            r_wdata  <= w_wdata_next;
            r_rw     <= w_rw_next;
            r_strobe <= (w_state_next == ST_STROBE);
            r_busy   <= (w_state_next != ST_IDLE);
            r_err    <= w_err_next;
            r_to_cnt <= w_to_next;
        end
    end

    assign o_tx_byte    = r_tx;
    assign o_bus_addr   = r_addr;
    assign o_bus_wdata  = r_wdata;
    assign o_bus_rw     = r_rw;
    assign o_bus_strobe = r_strobe;
    assign o_busy       = r_busy;
    assign o_err        = r_err;

endmodule

// File: tb/tb_spi_bus_sequencer.sv
// Bench for spi_bus_sequencer: two builds (2 wait states / timeout 255 and
// 5 wait states / timeout 12) driven by shared stimulus and per-build models.
module tb_spi_bus_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_l;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] bus_rdata;

    logic [7:0] o_tx   [2];
    logic [7:0] o_addr [2];
    logic [7:0] o_wd   [2];
    logic       o_rw   [2];
    logic       o_stb  [2];
    logic       o_busy [2];
    logic       o_err  [2];

    spi_bus_sequencer #(.WAIT_STATES(2), .TIMEOUT(255)) dut0 (
        .i_clk(clk), .i_rst_l(rst_l), .i_rx_byte(rx_byte), .i_rx_valid(rx_valid),
        .o_tx_byte(o_tx[0]), .o_bus_addr(o_addr[0]), .o_bus_wdata(o_wd[0]),
        .i_bus_rdata(bus_rdata), .o_bus_rw(o_rw[0]), .o_bus_strobe(o_stb[0]),
        .o_busy(o_busy[0]), .o_err(o_err[0])
    );

    spi_bus_sequencer #(.WAIT_STATES(5), .TIMEOUT(12)) dut1 (
        .i_clk(clk), .i_rst_l(rst_l), .i_rx_byte(rx_byte), .i_rx_valid(rx_valid),
        .o_tx_byte(o_tx[1]), .o_bus_addr(o_addr[1]), .o_bus_wdata(o_wd[1]),
        .i_bus_rdata(bus_rdata), .o_bus_rw(o_rw[1]), .o_bus_strobe(o_stb[1]),
        .o_busy(o_busy[1]), .o_err(o_err[1])
    );

    function automatic int ws_of(input int k);
        return (k == 0) ? 2 : 5;
    endfunction

    function automatic int to_of(input int k);
        return (k == 0) ? 255 : 12;
    endfunction

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: mode 0 idle, 1 waiting for write data, 2 bus cycle.
    // m_t0 is the cycle the triggering byte was presented.
    int         m_mode [2];
    int         m_t0   [2];
    logic [7:0] e_tx   [2];
    logic [7:0] e_addr [2];
    logic [7:0] e_wd   [2];
    logic       e_rw   [2];
    logic       e_err  [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_t0[k] = 0;
            e_tx[k] = 8'h00; e_addr[k] = 8'h00; e_wd[k] = 8'h00;
            e_rw[k] = 1'b1; e_err[k] = 1'b0;
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            string p;
            logic  e_stb;
            logic  e_busy;
            p      = (k == 0) ? "d0_" : "d1_";
            e_busy = (m_mode[k] != 0);
            e_stb  = (m_mode[k] == 2) && (cyc >= m_t0[k] + 2) && (cyc <= m_t0[k] + 1 + ws_of(k));
            check_eq({p, "strobe"}, 32'(o_stb[k]),  32'(e_stb));
            check_eq({p, "busy"},   32'(o_busy[k]), 32'(e_busy));
            check_eq({p, "err"},    32'(o_err[k]),  32'(e_err[k]));
            check_eq({p, "tx"},     32'(o_tx[k]),   32'(e_tx[k]));
            check_eq({p, "addr"},   32'(o_addr[k]), 32'(e_addr[k]));
            check_eq({p, "wdata"},  32'(o_wd[k]),   32'(e_wd[k]));
            check_eq({p, "rw"},     32'(o_rw[k]),   32'(e_rw[k]));
        end
    endtask

    task automatic model_apply(input logic v, input logic [7:0] b, input logic [7:0] rd);
        for (int k = 0; k < 2; k++) begin
            case (m_mode[k])
                0: if (v) begin
                    e_addr[k] = (b >> 1) & 8'h3F;
                    m_t0[k]   = cyc;
                    if (b[7]) begin
                        e_rw[k]   = 1'b1;
                        m_mode[k] = 2;
                    end else begin
                        m_mode[k] = 1;
                    end
                end
                1: if (v) begin
                    e_wd[k]   = b;
                    e_rw[k]   = 1'b0;
                    m_mode[k] = 2;
                    m_t0[k]   = cyc;
                end else if (cyc == m_t0[k] + to_of(k)) begin
                    e_err[k]  = 1'b1;
                    m_mode[k] = 0;
                end
                default: begin
                    if (v) e_err[k] = 1'b1;
                    if (e_rw[k] && cyc == m_t0[k] + 1 + ws_of(k)) e_tx[k] = rd;
                    if (cyc == m_t0[k] + 2 + ws_of(k)) m_mode[k] = 0;
                end
            endcase
        end
    endtask

    // One clock cycle: drive inputs just after the edge, compare at the falling edge.
    task automatic step(input logic v, input logic [7:0] b, input logic [7:0] rd);
        rx_valid  = v;
        rx_byte   = b;
        bus_rdata = rd;
        @(negedge clk);
        compare_all();
        model_apply(v, b, rd);
        @(posedge clk);
        #1;
        cyc++;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n, input logic [7:0] rd);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), rd);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must drop before any edge.
    task automatic do_reset();
        rx_valid = 1'b0;
        #2;
        rst_l = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq("rst_strobe", 32'(o_stb[k]),  32'h0);
            check_eq("rst_busy",   32'(o_busy[k]), 32'h0);
            check_eq("rst_err",    32'(o_err[k]),  32'h0);
            check_eq("rst_tx",     32'(o_tx[k]),   32'h00);
            check_eq("rst_addr",   32'(o_addr[k]), 32'h00);
            check_eq("rst_wdata",  32'(o_wd[k]),   32'h00);
            check_eq("rst_rw",     32'(o_rw[k]),   32'h1);
        end
        repeat (2) @(posedge clk);
        #3;
        rst_l = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst_l = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; bus_rdata = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #3 rst_l = 1'b1;
        @(posedge clk);
        #1;

        // Read 0x85 -> address 0x02, rdata A5 returned on tx.
        step(1'b1, 8'h85, 8'hA5);
        idle(10, 8'hA5);
        check_eq("read_addr", 32'(o_addr[0]), 32'h02);
        check_eq("read_tx",   32'(o_tx[0]),   32'hA5);

        // Write 0x0A then 0x3C ten clocks later.
        step(1'b1, 8'h0A, 8'h11);
        idle(9, 8'h11);
        step(1'b1, 8'h3C, 8'h11);
        idle(10, 8'h11);
        check_eq("wr_addr",  32'(o_addr[0]), 32'h05);
        check_eq("wr_wdata", 32'(o_wd[0]),   32'h3C);
        check_eq("wr_rw",    32'(o_rw[0]),   32'h0);
        check_eq("wr_tx",    32'(o_tx[0]),   32'hA5);

        // Data byte exactly 255 clocks after the command is still accepted.
        step(1'b1, 8'h0A, 8'h22);
        idle(254, 8'h22);
        step(1'b1, 8'hF7, 8'h22);
        idle(8, 8'h22);
        check_eq("to_edge_err",   32'(o_err[0]), 32'h0);
        check_eq("to_edge_wdata", 32'(o_wd[0]),  32'hF7);

        // No data byte within 255 clocks -> error, back to idle.
        do_reset();
        step(1'b1, 8'h0A, 8'h33);
        idle(258, 8'h33);
        check_eq("to_err",  32'(o_err[0]),  32'h1);
        check_eq("to_busy", 32'(o_busy[0]), 32'h0);

        // Second byte during STROBE is dropped and flagged.
        do_reset();
        step(1'b1, 8'h81, 8'h5A);
        step(1'b0, 8'h00, 8'h5A);
        step(1'b1, 8'h55, 8'h5A);
        idle(10, 8'h5A);
        check_eq("ovr_err",  32'(o_err[0]),  32'h1);
        check_eq("ovr_tx",   32'(o_tx[0]),   32'h5A);
        check_eq("ovr_busy", 32'(o_busy[0]), 32'h0);

        // Reset asserted while the strobe is high.
        do_reset();
        step(1'b1, 8'h85, 8'h66);
        step(1'b0, 8'h00, 8'h66);
        step(1'b0, 8'h00, 8'h66);
        check_eq("pre_rst_strobe", 32'(o_stb[0]), 32'h1);
        do_reset();

        // Randomized traffic with varying byte density.
        for (int seg = 0; seg < 16; seg++) begin
            int pct;
            int len;
            pct = $urandom_range(2, 40);
            len = $urandom_range(60, 200);
            for (int i = 0; i < len; i++) begin
                step(1'($urandom_range(0, 99) < pct), 8'($urandom), 8'($urandom));
            end
            do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
